// File: rtl/bulk_line_adapter_if.sv
// Bulk cache-line request/response port shared by the cache's bulk master and
// the memory-side adapter.
interface bulk_read_interface #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int LINE_SIZE = 8
);
  // Handshakes: a request transfers in a cycle where req_valid && req_ready;
  // the master holds its request fields stable while req_valid is high and
  // req_ready is low. resp_valid is a one-cycle pulse with no back-pressure.
  logic                                 req_valid;
  logic                                 req_ready;
  logic [ADDR_W-1:0]                    req_addr;
  logic                                 req_write;
  logic [LINE_SIZE-1:0][DATA_W-1:0]     req_wdata;
  logic [LINE_SIZE-1:0][DATA_W/8-1:0]   req_wstrb;
  logic                                 dumping_cache;
  logic                                 resp_valid;
  logic [LINE_SIZE-1:0][DATA_W-1:0]     resp_rdata;

  modport master (
    output req_valid, req_addr, req_write, req_wdata, req_wstrb, dumping_cache,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_write, req_wdata, req_wstrb, dumping_cache,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/bulk_line_adapter.sv
// Splits one whole-line bulk request into LINE_SIZE word beats on a narrow
// memory port and reassembles read responses into a line.
module bulk_line_adapter #(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int LINE_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bulk_read_interface.slave     line,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_req_addr,
  output logic                  mem_req_write,
  output logic [DATA_W-1:0]     mem_req_wdata,
  output logic [DATA_W/8-1:0]   mem_req_wstrb,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     mem_resp_rdata,
  output logic [1:0]            o_dbg_state
);
  localparam int SB         = DATA_W / 8;
  localparam int IW         = $clog2(LINE_SIZE);
  localparam int CW         = IW + 1;
  localparam int LINE_BYTES = LINE_SIZE * SB;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                          r_state, w_next;
  logic [ADDR_W-1:0]               r_base;
  logic                            r_write;
  logic [LINE_SIZE-1:0][DATA_W-1:0] r_wdata;
  logic [LINE_SIZE-1:0][SB-1:0]    r_wstrb;
  logic [CW-1:0]                   r_iss, r_rsp;
  logic [LINE_SIZE-1:0][DATA_W-1:0] r_asm, r_rdata, w_asm_next;

  logic [LINE_SIZE-1:0] w_pend, w_rest;
  logic [IW-1:0]        w_beat;
  logic                 w_have, w_fire, w_rsp_acc, w_accept;
  logic [CW-1:0]        w_rsp_next;
  logic                 w_unused;

  assign w_unused = line.dumping_cache;

  // Beats still to issue; zero-strobe write lanes never count as pending.
  always_comb begin
    w_pend = '0;
    for (int j = 0; j < LINE_SIZE; j++)
      w_pend[j] = (CW'(j) >= r_iss) && (!r_write || (|r_wstrb[j]));
  end

  always_comb begin
    w_beat = '0;
    for (int j = LINE_SIZE - 1; j >= 0; j--)
      if (w_pend[j]) w_beat = IW'(j);
  end

  assign w_rest   = w_pend & ~(LINE_SIZE'(1) << w_beat);
  assign w_have   = |w_pend;
  assign w_accept = (r_state == S_IDLE) && line.req_valid;

  assign mem_req_valid = (r_state == S_ISSUE) && w_have;
  assign w_fire        = mem_req_valid && mem_req_ready;
  assign mem_req_write = mem_req_valid && r_write;
  assign mem_req_addr  = mem_req_valid ? r_base + ADDR_W'(w_beat) * ADDR_W'(SB) : '0;
  assign mem_req_wdata = mem_req_valid ? r_wdata[w_beat] : '0;
  assign mem_req_wstrb = mem_req_valid ? r_wstrb[w_beat] : '0;

  // A response only counts while some read beat is outstanding.
  assign w_rsp_acc  = mem_resp_valid && (r_state == S_ISSUE || r_state == S_DRAIN) &&
                      (r_rsp != r_iss);
  assign w_rsp_next = r_rsp + CW'(w_rsp_acc);

  always_comb begin
    w_asm_next = r_asm;
    if (w_rsp_acc) w_asm_next[r_rsp[IW-1:0]] = mem_resp_rdata;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (line.req_valid) w_next = S_ISSUE;
      S_ISSUE: begin
        if (r_write) begin
          if (!w_have || (w_fire && w_rest == '0)) w_next = S_DONE;
        end else if (w_fire && w_rest == '0) begin
          w_next = (w_rsp_next == CW'(LINE_SIZE)) ? S_DONE : S_DRAIN;
        end
      end
      S_DRAIN: if (w_rsp_next == CW'(LINE_SIZE)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_base  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_iss   <= '0;
      r_rsp   <= '0;
      r_asm   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_base  <= line.req_addr & ~ADDR_W'(LINE_BYTES - 1);
        r_write <= line.req_write;
        r_wdata <= line.req_wdata;
        r_wstrb <= line.req_wstrb;
        r_iss   <= '0;
        r_rsp   <= '0;
      end
      if (w_fire) r_iss <= CW'(w_beat) + CW'(1);
      if (w_rsp_acc) begin
        r_rsp <= w_rsp_next;
        r_asm <= w_asm_next;
      end
      // The output line only changes on entry to DONE so it holds otherwise.
      if (w_next == S_DONE && r_state != S_DONE)
        r_rdata <= r_write ? '0 : w_asm_next;
    end
  end

  assign line.req_ready  = (r_state == S_IDLE);
  assign line.resp_valid = (r_state == S_DONE);
  assign line.resp_rdata = r_rdata;
  assign o_dbg_state     = r_state;
endmodule
